// File: rtl/demux_8way_reg.sv
// Eight-way registered demultiplexer: one single-entry buffer per output channel,
// valid/ready on the input side and per-channel valid/ready on the outputs.
module demux_8way_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_slct,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_e,
  output logic [WIDTH-1:0] out_f,
  output logic [WIDTH-1:0] out_g,
  output logic [WIDTH-1:0] out_h,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [3:0]       occupancy
);

  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_n [8];
  logic [7:0]       valid_q;
  logic [7:0]       valid_n;
  logic [3:0]       occ_q;
  logic [3:0]       occ_n;
  logic             accept;
  logic [7:0]       drain;
  logic [7:0]       load;

  // A full channel can still take a word if its consumer empties it this cycle.
  assign in_ready = ~rst & (~valid_q[in_slct] | out_ready[in_slct]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    drain = '0;
    load  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      drain[i] = valid_q[i] & out_ready[i];
      load[i]  = accept & (in_slct == 3'(i));
    end
  end

  // Load wins over drain on the same channel; drained data is zeroed so the
  // output reads zero whenever the channel is empty.
  always_comb begin
    valid_n = valid_q;
    occ_n   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      data_n[i] = data_q[i];
      if (load[i]) begin
        data_n[i]  = in_data;
        valid_n[i] = 1'b1;
      end else if (drain[i]) begin
        data_n[i]  = '0;
        valid_n[i] = 1'b0;
      end
    end
    for (int unsigned i = 0; i < 8; i++) begin
      occ_n = occ_n + 4'(valid_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_n;
      occ_q   <= occ_n;
      for (int unsigned i = 0; i < 8; i++) begin
        data_q[i] <= data_n[i];
      end
    end
  end

  assign out_a     = data_q[0];
  assign out_b     = data_q[1];
  assign out_c     = data_q[2];
  assign out_d     = data_q[3];
  assign out_e     = data_q[4];
  assign out_f     = data_q[5];
  assign out_g     = data_q[6];
  assign out_h     = data_q[7];
  assign out_valid = valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_demux_8way_reg.sv
// Table-driven bench for demux_8way_reg: each vector is driven after a falling
// edge, in_ready is checked before the rising edge, registered outputs after it.
module tb_demux_8way_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] in_slct;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [3:0] occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_8way_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_slct   (in_slct),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_g     (out_g),
    .out_h     (out_h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        iv;
    logic [2:0]  sl;
    logic [7:0]  d;
    logic [7:0]  ordy;
    logic        exp_rdy;
    logic [7:0]  exp_vld;
    logic [3:0]  exp_occ;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] all_data();
    return {out_h, out_g, out_f, out_e, out_d, out_c, out_b, out_a};
  endfunction

  task automatic add(input string name, input logic r, input logic iv, input logic [2:0] sl,
                     input logic [7:0] d, input logic [7:0] ordy, input logic erdy,
                     input logic [7:0] evld, input logic [3:0] eocc, input logic [63:0] edata);
    vec_t v;
    v.name = name; v.rst = r; v.iv = iv; v.sl = sl; v.d = d; v.ordy = ordy;
    v.exp_rdy = erdy; v.exp_vld = evld; v.exp_occ = eocc; v.exp_data = edata;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_slct = '0; in_data = '0; out_ready = '0;

    //   name            rst iv sl    data   ordy   rdy vld    occ data(h..a)
    add("rst1",          1, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0, 64'h0);
    add("rst2",          1, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0, 64'h0);
    add("post_rst",      0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h00, 0, 64'h0);
    add("fill_a",        0, 1, 3'd0, 8'd10, 8'h00, 1, 8'h01, 1, 64'h00000000_0000000A);
    add("fill_b",        0, 1, 3'd1, 8'd20, 8'h00, 1, 8'h03, 2, 64'h00000000_0000140A);
    add("fill_c",        0, 1, 3'd2, 8'd30, 8'h00, 1, 8'h07, 3, 64'h00000000_001E140A);
    add("fill_d",        0, 1, 3'd3, 8'd40, 8'h00, 1, 8'h0F, 4, 64'h00000000_281E140A);
    add("fill_e",        0, 1, 3'd4, 8'd50, 8'h00, 1, 8'h1F, 5, 64'h00000032_281E140A);
    add("fill_f",        0, 1, 3'd5, 8'd60, 8'h00, 1, 8'h3F, 6, 64'h00003C32_281E140A);
    add("fill_g",        0, 1, 3'd6, 8'd70, 8'h00, 1, 8'h7F, 7, 64'h00463C32_281E140A);
    add("fill_h",        0, 1, 3'd7, 8'd80, 8'h00, 1, 8'hFF, 8, 64'h50463C32_281E140A);
    add("full_block",    0, 1, 3'd3, 8'h63, 8'h00, 0, 8'hFF, 8, 64'h50463C32_281E140A);
    add("drain_acc_c",   0, 1, 3'd2, 8'h63, 8'h04, 1, 8'hFF, 8, 64'h50463C32_2863140A);
    add("bulk_drain",    0, 0, 3'd0, 8'h00, 8'hFF, 1, 8'h00, 0, 64'h0);
    add("acc_f",         0, 1, 3'd5, 8'h77, 8'h00, 1, 8'h20, 1, 64'h00007700_00000000);
    add("idle0",         0, 0, 3'd0, 8'h00, 8'hDF, 1, 8'h20, 1, 64'h00007700_00000000);
    add("idle1",         0, 0, 3'd0, 8'h00, 8'hDF, 1, 8'h20, 1, 64'h00007700_00000000);
    add("idle2",         0, 0, 3'd0, 8'h00, 8'hDF, 1, 8'h20, 1, 64'h00007700_00000000);
    add("acc_b_drain_f", 0, 1, 3'd1, 8'h11, 8'h20, 1, 8'h02, 1, 64'h00000000_00001100);
    add("drain_b",       0, 0, 3'd0, 8'h00, 8'h02, 1, 8'h00, 0, 64'h0);
    add("refill_a",      0, 1, 3'd0, 8'h01, 8'h00, 1, 8'h01, 1, 64'h00000000_00000001);
    add("refill_b",      0, 1, 3'd1, 8'h02, 8'h00, 1, 8'h03, 2, 64'h00000000_00000201);
    add("refill_c",      0, 1, 3'd2, 8'h03, 8'h00, 1, 8'h07, 3, 64'h00000000_00030201);
    add("refill_d",      0, 1, 3'd3, 8'h04, 8'h00, 1, 8'h0F, 4, 64'h00000000_04030201);
    add("refill_e",      0, 1, 3'd4, 8'h05, 8'h00, 1, 8'h1F, 5, 64'h00000005_04030201);
    add("rst_mid",       1, 1, 3'd6, 8'h55, 8'h00, 0, 8'h00, 0, 64'h0);
    add("acc_g_post_rst",0, 1, 3'd6, 8'h55, 8'h00, 1, 8'h40, 1, 64'h00550000_00000000);
    add("drain_acc_g",   0, 1, 3'd6, 8'h66, 8'h40, 1, 8'h40, 1, 64'h00660000_00000000);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst; in_valid = vecs[k].iv; in_slct = vecs[k].sl;
      in_data = vecs[k].d; out_ready = vecs[k].ordy;
      #1;
      if (k >= 2) chk({vecs[k].name, ".in_ready"}, 64'(in_ready), 64'(vecs[k].exp_rdy));
      @(posedge clk);
      #1;
      chk({vecs[k].name, ".out_valid"}, 64'(out_valid), 64'(vecs[k].exp_vld));
      chk({vecs[k].name, ".occupancy"}, 64'(occupancy), 64'(vecs[k].exp_occ));
      chk({vecs[k].name, ".data"}, all_data(), vecs[k].exp_data);
    end

    // Latency: word on h must not appear before the edge, and must appear right after it.
    @(negedge clk);
    in_valid = 1'b1; in_slct = 3'd7; in_data = 8'hA5; out_ready = 8'h00;
    #1;
    chk("lat.in_ready", 64'(in_ready), 64'd1);
    chk("lat.pre_valid", 64'(out_valid), 64'h40);
    chk("lat.pre_out_h", 64'(out_h), 64'h00);
    @(posedge clk);
    #1;
    chk("lat.post_valid", 64'(out_valid), 64'hC0);
    chk("lat.post_out_h", 64'(out_h), 64'hA5);
    chk("lat.post_occ", 64'(occupancy), 64'd2);

    // in_ready must not depend on in_valid.
    @(negedge clk);
    in_valid = 1'b0; in_slct = 3'd7; out_ready = 8'h00;
    #1;
    chk("rdy_indep.iv0_full", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    #1;
    chk("rdy_indep.iv1_full", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 8'h80;
    #1;
    chk("rdy_indep.iv0_draining", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("rdy_indep.drain_h_valid", 64'(out_valid), 64'h40);
    chk("rdy_indep.drain_h_data", 64'(out_h), 64'h00);
    chk("rdy_indep.drain_h_occ", 64'(occupancy), 64'd1);

    @(negedge clk);
    out_ready = 8'h00;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_8way_reg.md
DEMUX_8WAY_REG -- requirements
Module: demux_8way_reg

Interface
REQ-001 Parameter: WIDTH, 8, data width of the input and of every output channel; all widths below are stated for WIDTH=8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  8  word to route.
REQ-005 in_slct  input  3  destination channel: 0=a, 1=b, ... 7=h.
REQ-006 in_valid  input  1  in_data and in_slct are valid this cycle.
REQ-007 in_ready  output  1  the addressed channel can accept this cycle.
REQ-008 out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h  output  8 each  per-channel buffered data.
REQ-009 out_valid  output  8  bit i set = channel i holds a word (bit 0 = a).
REQ-010 out_ready  input  8  bit i set = consumer of channel i takes the word this cycle.
REQ-011 occupancy  output  4  number of full channels, 0..8.

Function
REQ-012 Each channel SHALL have exactly one buffer entry: an 8-bit data register and a valid bit.
REQ-013 in_ready SHALL be combinational: rst low AND (out_valid[in_slct]=0 OR out_ready[in_slct]=1).
- in_ready does not depend on in_valid.
REQ-014 Accept SHALL occur at a rising edge with in_valid=1 AND in_ready=1.
- Channel in_slct data <= in_data; valid <= 1.
REQ-015 Drain SHALL occur at a rising edge with out_valid[i]=1 AND out_ready[i]=1.
- Channel i valid <= 0; data <= 0.
- Exception: REQ-016 applies when a simultaneous accept targets channel i.
REQ-016 Simultaneous drain and accept on the same channel SHALL leave valid=1 and load the new in_data; the old word counts as consumed.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N appears on out_x with out_valid set immediately after edge N.
REQ-018 An out_x output SHALL read 8'h00 whenever its valid bit is 0.
REQ-019 Unselected channels SHALL be unaffected by an accept.
- Drains on any subset of channels SHALL proceed in the same cycle as an accept.
REQ-020 out_ready[i] SHALL be ignored while out_valid[i]=0.
REQ-021 in_valid=1 with in_ready=0 SHALL cause no state change; the producer holds in_data and in_slct until accepted.
REQ-022 occupancy SHALL equal the popcount of out_valid and SHALL be registered consistently with out_valid in the same cycle.
REQ-023 Per-channel order SHALL be preserved.
- No word is dropped or duplicated.
- A word is never written to a channel other than in_slct.

Reset
REQ-024 rst high at a rising edge SHALL clear all valid bits, all data registers and occupancy to 0.
- Reset has priority over any simultaneous accept or drain.
REQ-025 While rst is high, in_ready SHALL be 0.
REQ-026 After rst deasserts, the first accept SHALL be possible at the next rising edge.

Verification
REQ-027 Reset: rst=1 for 2 cycles, then 0 -> out_valid=8'h00, out_a..out_h=0, occupancy=0, in_ready=1.
REQ-028 Fill:
- Stimulus: out_ready=8'h00; write 10,20,...,80 to slct 0..7 on consecutive cycles.
- Required: out_valid=8'hFF; out_a=10 ... out_h=80; occupancy=8.
- Then in_valid=1, slct=3, data=99 -> in_ready=0; out_d remains 40.
REQ-029 Drain+accept:
- Stimulus: channel c holds 30; out_ready[2]=1; in_valid=1, slct=2, data=99.
- Required: in_ready=1; next cycle out_c=99, out_valid[2]=1, occupancy unchanged.
REQ-030 Bulk drain: all channels full; out_ready=8'hFF, in_valid=0 -> next cycle out_valid=8'h00, all outputs 0, occupancy=0.
REQ-031 Reset mid-operation:
- Stimulus: channels a..e full; in_valid=1, slct=6, data=55; rst=1 for one edge.
- Required: all cleared; out_g=0; occupancy=0.
REQ-032 Idle: in_valid=0 with in_ready=1 for 3 cycles -> no change to any output or to occupancy.
